// File: rtl/agc_stim_sequencer.sv
// Table-driven stimulus sequencer: plays loaded SET/PULSE events onto NCH control lines
// with per-event cycle delays, one-shot or looped, abortable back to the idle pattern.
module agc_stim_sequencer #(
  parameter int NCH      = 16,
  parameter int DEPTH    = 32,
  parameter int DLY_W    = 20,
  parameter int PULSE_W  = 4,
  parameter logic [NCH-1:0] IDLE_VAL = {NCH{1'b1}},
  localparam int CH_W    = $clog2(NCH),
  localparam int IDX_W   = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK,
  input  logic             SIM_RST,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [DLY_W-1:0] ld_delay,
  input  logic [CH_W-1:0]  ld_chan,
  input  logic             ld_level,
  input  logic             ld_pulse,
  input  logic             clear,
  input  logic             start,
  input  logic             loop,
  input  logic             abort,
  output logic [NCH-1:0]   chan_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] ev_idx,
  output logic [IDX_W-1:0] count,
  output logic             err
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW_W = $clog2(PULSE_W) + 1;

  typedef struct packed {
    logic [DLY_W-1:0] delay;
    logic [CH_W-1:0]  chan;
    logic             level;
    logic             pulse;
  } ev_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  ev_t              mem [DEPTH];
  ev_t              ent_q;
  ev_t              wr_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] ev_idx_q, ev_idx_d;
  logic [DLY_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [NCH-1:0]   chan_out_q, chan_out_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             loop_q, loop_d;
  logic             pend_q, pend_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic             pend_lvl_q, pend_lvl_d;
  logic [PW_W-1:0]  pend_cnt_q, pend_cnt_d;

  logic             fire;
  logic             last_ev;
  logic             restore_due;

  assign ld_ready    = (state_q == S_IDLE) && (32'(count_q) < DEPTH) && !abort;
  assign fire        = (state_q == S_WAIT) && (wait_cnt_q == ent_q.delay);
  assign last_ev     = (ev_idx_q == IDX_W'(count_q - 1'b1));
  assign restore_due = pend_q && (pend_cnt_q == '0);
  assign wr_addr     = count_q[AW-1:0];
  assign rd_addr     = ev_idx_d[AW-1:0];
  assign wr_data     = '{delay: ld_delay, chan: ld_chan, level: ld_level, pulse: ld_pulse};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ev_idx_d   = ev_idx_q;
    wait_cnt_d = wait_cnt_q;
    chan_out_d = chan_out_q;
    done_d     = 1'b0;
    err_d      = err_q;
    loop_d     = loop_q;
    pend_d     = pend_q;
    pend_ch_d  = pend_ch_q;
    pend_lvl_d = pend_lvl_q;
    pend_cnt_d = pend_cnt_q;
    wr_en      = 1'b0;

    if (abort) begin
      chan_out_d = IDLE_VAL;
      pend_d     = 1'b0;
      state_d    = S_IDLE;
      ev_idx_d   = '0;
      wait_cnt_d = '0;
    end else begin
      // A new PULSE forces the outstanding restore out first so only one is ever pending.
      if (restore_due || (fire && ent_q.pulse && pend_q)) begin
        chan_out_d[pend_ch_q] = pend_lvl_q;
        pend_d = 1'b0;
      end else if (pend_q) begin
        pend_cnt_d = pend_cnt_q - 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          ev_idx_d = '0;
          if (clear) begin
            count_d = '0;
          end else if (ld_valid && ld_ready) begin
            if (32'(ld_chan) >= NCH) begin
              err_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
          if (start) begin
            if ((count_q != '0) && !clear) begin
              state_d    = S_WAIT;
              wait_cnt_d = '0;
              loop_d     = loop;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (fire) begin
            chan_out_d[ent_q.chan] = ent_q.level;
            if (ent_q.pulse) begin
              pend_d     = 1'b1;
              pend_ch_d  = ent_q.chan;
              pend_lvl_d = !ent_q.level;
              pend_cnt_d = PW_W'(PULSE_W - 1);
            end
            wait_cnt_d = '0;
            if (last_ev) begin
              ev_idx_d = '0;
              if (!loop_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              ev_idx_d = ev_idx_q + 1'b1;
            end
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Event table with registered read; ent_q always holds the entry at ev_idx.
  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    ent_q <= mem[rd_addr];
  end

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      ev_idx_q   <= '0;
      wait_cnt_q <= '0;
      chan_out_q <= IDLE_VAL;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      loop_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_lvl_q <= 1'b0;
      pend_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ev_idx_q   <= ev_idx_d;
      wait_cnt_q <= wait_cnt_d;
      chan_out_q <= chan_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
      loop_q     <= loop_d;
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_lvl_q <= pend_lvl_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign chan_out = chan_out_q;
  assign busy     = (state_q == S_WAIT);
  assign done     = done_q;
  assign ev_idx   = ev_idx_q;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_agc_stim_sequencer.sv
// Scoreboard bench: stimulus queues expected chan_out changes / done pulses with their edge
// numbers; a monitor pops and compares each time the DUT shows one.
module tb_agc_stim_sequencer;

  localparam int NCH     = 12;
  localparam int DEPTH   = 8;
  localparam int DLY_W   = 20;
  localparam int PULSE_W = 4;
  localparam int CH_W    = $clog2(NCH);
  localparam int IDX_W   = $clog2(DEPTH + 1);
  localparam logic [NCH-1:0] IDLE = 12'hFFF;

  logic             CLOCK = 1'b0;
  logic             SIM_RST;
  logic             ld_valid, ld_ready, ld_level, ld_pulse;
  logic [DLY_W-1:0] ld_delay;
  logic [CH_W-1:0]  ld_chan;
  logic             clear, start, loop, abort;
  logic [NCH-1:0]   chan_out;
  logic             busy, done, err;
  logic [IDX_W-1:0] ev_idx, count;

  agc_stim_sequencer #(
    .NCH(NCH), .DEPTH(DEPTH), .DLY_W(DLY_W), .PULSE_W(PULSE_W), .IDLE_VAL(IDLE)
  ) dut (
    .CLOCK(CLOCK), .SIM_RST(SIM_RST),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_delay(ld_delay), .ld_chan(ld_chan),
    .ld_level(ld_level), .ld_pulse(ld_pulse),
    .clear(clear), .start(start), .loop(loop), .abort(abort),
    .chan_out(chan_out), .busy(busy), .done(done), .ev_idx(ev_idx), .count(count), .err(err)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    int             at;
    bit             is_done;
    logic [NCH-1:0] val;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("ok   %-20s got %0h @cyc %0d", name, got, cyc);
    end else begin
      $display("FAIL %s: got %0h want %0h @cyc %0d", name, got, want, cyc);
    end
  endfunction

  function automatic void exp_chg(input int at, input logic [NCH-1:0] v);
    exp_t e;
    e.at = at; e.is_done = 1'b0; e.val = v;
    expq.push_back(e);
  endfunction

  function automatic void exp_done(input int at);
    exp_t e;
    e.at = at; e.is_done = 1'b1; e.val = '0;
    expq.push_back(e);
  endfunction

  function automatic void observe(input bit is_done, input logic [NCH-1:0] v);
    exp_t e;
    n_checks++;
    if (expq.size() == 0) begin
      $display("FAIL unexpected_%s: got %0h at cyc %0d, nothing expected",
               is_done ? "done" : "chg", v, cyc);
      return;
    end
    e = expq.pop_front();
    if (e.is_done == is_done && e.at == cyc && (is_done || e.val === v)) begin
      n_pass++;
      $display("ok   sb_%s val %0h @cyc %0d", is_done ? "done" : "chg ", v, cyc);
    end else begin
      $display("FAIL sb_event: got %s %0h @cyc %0d want %s %0h @cyc %0d",
               is_done ? "done" : "chg", v, cyc, e.is_done ? "done" : "chg", e.val, e.at);
    end
  endfunction

  // Monitor
  initial begin
    logic [NCH-1:0] prev_out;
    prev_out = IDLE;
    forever begin
      @(negedge CLOCK);
      if (mon_en) begin
        if (chan_out !== prev_out) begin
          observe(1'b0, chan_out);
          prev_out = chan_out;
        end
        if (done === 1'b1) observe(1'b1, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input int d, input int ch, input bit lvl, input bit pl);
    ld_valid = 1'b1;
    ld_delay = DLY_W'(d);
    ld_chan  = CH_W'(ch);
    ld_level = lvl;
    ld_pulse = pl;
    @(negedge CLOCK);
    ld_valid = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    @(negedge CLOCK);
    clear = 1'b0;
  endtask

  task automatic go(input bit lp);
    start = 1'b1;
    loop  = lp;
    @(negedge CLOCK);
    start = 1'b0;
    loop  = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLOCK);
  endtask

  initial begin
    int e0;
    SIM_RST = 1'b1; ld_valid = 1'b0; ld_delay = '0; ld_chan = '0; ld_level = 1'b0;
    ld_pulse = 1'b0; clear = 1'b0; start = 1'b0; loop = 1'b0; abort = 1'b0;
    repeat (3) @(negedge CLOCK);
    SIM_RST = 1'b0;
    chk("rst_chan_out", 32'(chan_out), 32'(IDLE));
    chk("rst_count", 32'(count), 0);
    chk("rst_ev_idx", 32'(ev_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    mon_en = 1'b1;

    // Three SET events, one-shot
    wr(3, 0, 0, 0); wr(0, 0, 1, 0); wr(5, 1, 0, 0);
    chk("t1_count", 32'(count), 3);
    e0 = cyc + 1;
    exp_chg(e0 + 4, 12'hFFE); exp_chg(e0 + 5, 12'hFFF);
    exp_chg(e0 + 11, 12'hFFD); exp_done(e0 + 11);
    go(1'b0);
    chk("t1_busy_start", 32'(busy), 1);
    wait_until(e0 + 10);
    chk("t1_busy_last", 32'(busy), 1);
    chk("t1_ev_idx", 32'(ev_idx), 2);
    wait_until(e0 + 11);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_ev_idx_end", 32'(ev_idx), 0);
    exp_chg(cyc + 1, IDLE);
    abort = 1'b1; @(negedge CLOCK); abort = 1'b0;
    chk("t1_count_kept", 32'(count), 3);

    // Table full, ignored extra write, clear vs write
    clr();
    for (int i = 0; i < DEPTH; i++) wr(i, i, 1, 0);
    chk("t2_ready_full", 32'(ld_ready), 0);
    chk("t2_count_full", 32'(count), DEPTH);
    wr(0, NCH, 0, 0);
    chk("t2_count_ignored", 32'(count), DEPTH);
    chk("t2_err_ignored", 32'(err), 0);
    clr();
    chk("t2_count_clear", 32'(count), 0);
    chk("t2_ready_clear", 32'(ld_ready), 1);
    wr(0, 1, 0, 0);
    clear = 1'b1; ld_valid = 1'b1; ld_chan = 4'd2;
    @(negedge CLOCK);
    clear = 1'b0; ld_valid = 1'b0;
    chk("t2_clear_wins", 32'(count), 0);

    // Back-to-back PULSEs on one channel
    wr(2, 3, 0, 1); wr(0, 3, 0, 1);
    e0 = cyc + 1;
    exp_chg(e0 + 3, 12'hFF7); exp_done(e0 + 4); exp_chg(e0 + 8, 12'hFFF);
    go(1'b0);
    wait_until(e0 + 7);
    chk("t3_restore_replaced", 32'(chan_out), 32'h0FF7);
    wait_until(e0 + 9);
    chk("t3_busy", 32'(busy), 0);

    // PULSE restore outlives playback
    clr();
    wr(2, 3, 0, 1); wr(1, 5, 0, 0);
    e0 = cyc + 1;
    exp_chg(e0 + 3, 12'hFF7); exp_chg(e0 + 5, 12'hFD7); exp_done(e0 + 5);
    exp_chg(e0 + 7, 12'hFDF);
    go(1'b0);
    wait_until(e0 + 8);
    exp_chg(cyc + 1, IDLE);
    abort = 1'b1; @(negedge CLOCK); abort = 1'b0;

    // Looped playback and abort
    clr();
    wr(1, 0, 0, 0); wr(1, 0, 1, 0);
    e0 = cyc + 1;
    exp_chg(e0 + 2, 12'hFFE); exp_chg(e0 + 4, 12'hFFF);
    exp_chg(e0 + 6, 12'hFFE); exp_chg(e0 + 7, IDLE);
    go(1'b1);
    chk("t4_ev_idx0", 32'(ev_idx), 0);
    wait_until(e0 + 2);
    chk("t4_ev_idx1", 32'(ev_idx), 1);
    wait_until(e0 + 4);
    chk("t4_ev_idx_wrap", 32'(ev_idx), 0);
    chk("t4_busy_loop", 32'(busy), 1);
    wait_until(e0 + 6);
    abort = 1'b1; @(negedge CLOCK); abort = 1'b0;
    chk("t4_busy_abort", 32'(busy), 0);
    chk("t4_done_abort", 32'(done), 0);
    chk("t4_count_kept", 32'(count), 2);

    // Bad channel, empty start
    wr(0, NCH, 0, 0);
    chk("t5_err", 32'(err), 1);
    chk("t5_count", 32'(count), 2);
    clr();
    e0 = cyc + 1;
    exp_done(e0);
    go(1'b0);
    chk("t5_chan_unchanged", 32'(chan_out), 32'(IDLE));
    chk("t5_busy", 32'(busy), 0);

    // Reset mid-playback
    wr(3, 2, 0, 0); wr(10, 4, 0, 0);
    e0 = cyc + 1;
    exp_chg(e0 + 4, 12'hFFB); exp_chg(e0 + 7, IDLE);
    go(1'b0);
    wait_until(e0 + 6);
    SIM_RST = 1'b1; @(negedge CLOCK); SIM_RST = 1'b0;
    chk("t6_chan_out", 32'(chan_out), 32'(IDLE));
    chk("t6_count", 32'(count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err), 0);

    repeat (10) @(negedge CLOCK);
    chk("sb_drained", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
